alu_op_sequencer: RTL and testbench

//  Upstream command stage for the ALU. Buffers incoming {opcode,A,B} commands in a small FIFO
//  and issues them one at a time to the ALU's registered interface (OPCODE/A/B/en/oe).

---
 rtl/alu_op_sequencer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Upstream command stage for a registered ALU. Commands {opcode, A, B} are
// buffered in a small FIFO and issued one at a time to the ALU: operands are
// loaded, alu_en is pulsed for one cycle, then alu_oe is raised for one cycle
// while ALU_OUT and the flags are captured. The captured result is offered on
// a valid/ready result port and held until the consumer takes it.
//
// Parameters
//   WIDTH  operand/result width (must match the ALU)
//   DEPTH  command FIFO entries, power of 2, >= 2
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   in_valid/in_ready         command handshake (in_ready = FIFO not full)
//   in_opcode/in_a/in_b       command fields
//   alu_opcode/alu_a/alu_b    registered operands to the ALU
//   alu_en/alu_oe             ALU enable (ISSUE) and output enable (CAPTURE)
//   alu_out/alu_flags         ALU result and {CF,OF,SF,ZF}
//   res_valid/res_ready       result handshake
//   res_data/res_flags        captured ALU result and flags
//   res_err                   command had an illegal opcode
//   busy                      FSM active or commands pending
//   op_count                  handshaken results, wraps at 16 bits
//
// Build option
//   ALU_SEQ_ILLEGAL_CHK_EN    when defined, opcodes outside 2..7 are never
//                             sent to the ALU; they complete immediately with
//                             res_data=0, res_flags=0, res_err=1. When not
//                             defined every opcode is issued and res_err=0.
//
// FSM states
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_IDLE    | nothing in flight; pop head of FIFO when one is present
//   S_ISSUE   | operands stable, alu_en pulsed for this single cycle
//   S_CAPTURE | alu_oe high; ALU result and flags latched at the edge
//   S_RESULT  | res_valid high, result held until res_ready
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,

  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_en,
  output logic             alu_oe,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags,

  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [3:0]       res_flags,
  output logic             res_err,

  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // ---------------------------------------------------------------------------
  // Command FIFO. Pointers carry one extra wrap bit so full and empty can be
  // told apart without a separate occupancy counter.
  // ---------------------------------------------------------------------------
  logic [3:0]       fifo_op [DEPTH];
  logic [WIDTH-1:0] fifo_a  [DEPTH];
  logic [WIDTH-1:0] fifo_b  [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             fifo_pop;

  logic [3:0]       head_op;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             head_illegal;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Acceptance depends only on the registered full flag, so a pop in the same
  // cycle never opens a slot early.
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;

  assign head_op = fifo_op[rd_ptr[AW-1:0]];
  assign head_a  = fifo_a[rd_ptr[AW-1:0]];
  assign head_b  = fifo_b[rd_ptr[AW-1:0]];

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  assign head_illegal = (head_op < 4'd2) || (head_op > 4'd7);
`else
  assign head_illegal = 1'b0;
`endif

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr[AW-1:0]] <= in_opcode;
      fifo_a[wr_ptr[AW-1:0]]  <= in_a;
      fifo_b[wr_ptr[AW-1:0]]  <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  logic load_cmd;
  logic load_illegal;
  logic capture;
  logic res_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    fifo_pop     = 1'b0;
    load_cmd     = 1'b0;
    load_illegal = 1'b0;
    capture      = 1'b0;
    res_hs       = 1'b0;
    alu_en       = 1'b0;
    alu_oe       = 1'b0;
    res_valid    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_illegal) begin
            load_illegal = 1'b1;
            state_next   = S_RESULT;
          end else begin
            load_cmd   = 1'b1;
            state_next = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        alu_en     = 1'b1;
        state_next = S_CAPTURE;
      end

      S_CAPTURE: begin
        alu_oe     = 1'b1;
        capture    = 1'b1;
        state_next = S_RESULT;
      end

      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          res_hs = 1'b1;
          // Chain straight into the next command to keep one op per 3 cycles.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            if (head_illegal) begin
              load_illegal = 1'b1;
              state_next   = S_RESULT;
            end else begin
              load_cmd   = 1'b1;
              state_next = S_ISSUE;
            end
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE) || !fifo_empty;

  // ---------------------------------------------------------------------------
  // Operand, result and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_opcode <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (load_cmd) begin
      alu_opcode <= head_op;
      alu_a      <= head_a;
      alu_b      <= head_b;
    end
  end

  // Capture only ever happens in CAPTURE with alu_oe high, so whatever the
  // ALU holds from before a reset is never observed on the result port.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data  <= '0;
      res_flags <= 4'd0;
    end else if (capture) begin
      res_data  <= alu_out;
      res_flags <= alu_flags;
    end else if (load_illegal) begin
      res_data  <= '0;
      res_flags <= 4'd0;
    end
  end

`ifdef ALU_SEQ_ILLEGAL_CHK_EN
  logic res_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_err_q <= 1'b0;
    end else if (capture) begin
      res_err_q <= 1'b0;
    end else if (load_illegal) begin
      res_err_q <= 1'b1;
    end
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= 16'd0;
    end else if (res_hs) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Drives alu_op_sequencer against a small behavioural ALU and checks every
// returned result against a queue of expected results built from accepted
// commands. Directed steps cover reset, latency, throughput, FIFO full,
// backpressure and illegal opcodes; a random phase follows.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_en;
  logic             alu_oe;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_flags;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       res_flags;
  logic             res_err;
  logic             busy;
  logic [15:0]      op_count;

  alu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_en     (alu_en),
    .alu_oe     (alu_oe),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .res_err    (res_err),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ALU behaviour: returns {CF,OF,SF,ZF, result}.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       cf, of;
    cf = 1'b0;
    of = 1'b0;
    case (op)
      4'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cf = s[8]; of = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd3: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; cf = s[8]; of = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~a;
      default: r = a;
    endcase
    return {cf, of, r[7], (r == 8'd0), r};
  endfunction

  // Expected result word {err, flags, data} for one command.
  function automatic logic [12:0] ref_result(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    if (op < 4'd2 || op > 4'd7) return 13'h1000;
`endif
    return {1'b0, alu_fn(op, a, b)};
  endfunction

  // Registered ALU: latches on en, drives its output only while oe is high.
  // A junk pattern otherwise exposes any capture outside CAPTURE.
  logic [11:0] alu_rf = 12'd0;
  int          en_total = 0;

  always @(posedge clk) begin
    if (alu_en) begin
      alu_rf   <= alu_fn(alu_opcode, alu_a, alu_b);
      en_total <= en_total + 1;
    end
  end

  assign alu_out   = alu_oe ? alu_rf[7:0]  : 8'hEE;
  assign alu_flags = alu_oe ? alu_rf[11:8] : 4'hE;

  // Reference model: ordered queue of expected results plus a handshake count.
  logic [12:0] exp_q[$];
  logic [15:0] exp_count = 16'd0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_count = 16'd0;
    end else begin
      chk("busy", busy, (exp_q.size() != 0));
      chk("op_count", op_count, exp_count);
      chk("en_oe_excl", alu_en & alu_oe, 1'b0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("res_unexpected", res_valid, 1'b0);
        end else begin
          chk("res_word", {res_err, res_flags, res_data}, exp_q.pop_front());
          exp_count = exp_count + 16'd1;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_result(in_opcode, in_a, in_b));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_res_valid(input int max, input string tag);
    int n = 0;
    while (!res_valid && n < max) begin
      cyc();
      n++;
    end
    chk({tag, "_tmo"}, res_valid, 1'b1);
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy && n < max) begin
      cyc();
      n++;
    end
    chk({tag, "_tmo"}, busy, 1'b0);
  endtask

  // One legal command with res_ready high, checked cycle by cycle from the
  // acceptance edge (cycle 0) through the handshake.
  task automatic run_single(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_d, input logic [3:0] exp_f, input string tag);
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    cyc();
    in_valid = 1'b0;
    chk({tag, "_c1_en"}, alu_en, 1'b0);
    chk({tag, "_c1_rv"}, res_valid, 1'b0);
    cyc();
    chk({tag, "_c2_en"}, alu_en, 1'b1);
    chk({tag, "_c2_oe"}, alu_oe, 1'b0);
    chk({tag, "_c2_ops"}, {alu_opcode, alu_a, alu_b}, {op, a, b});
    cyc();
    chk({tag, "_c3_en"}, alu_en, 1'b0);
    chk({tag, "_c3_oe"}, alu_oe, 1'b1);
    chk({tag, "_c3_rv"}, res_valid, 1'b0);
    cyc();
    chk({tag, "_c4_rv"}, res_valid, 1'b1);
    chk({tag, "_c4_data"}, res_data, exp_d);
    chk({tag, "_c4_flags"}, res_flags, exp_f);
    chk({tag, "_c4_oe"}, alu_oe, 1'b0);
    cyc();
    chk({tag, "_c5_rv"}, res_valid, 1'b0);
  endtask

  initial begin
    int hits[$];
    int e0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_opcode = 4'd0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_op_count", op_count, 16'd0);
    chk("rst_en_oe", {alu_en, alu_oe}, 2'b00);
    chk("rst_res", {res_err, res_flags, res_data}, 13'd0);
    chk("rst_alu_ops", {alu_opcode, alu_a, alu_b}, 20'd0);
    rst = 1'b0;
    cyc();

    // Directed operations
    run_single(4'd2, 8'h10, 8'h20, 8'h30, 4'b0000, "add");
    run_single(4'd4, 8'hF0, 8'h0F, 8'h00, 4'b0001, "and");
    run_single(4'd6, 8'hA5, 8'hFF, 8'h5A, 4'b0000, "xor");

    // Throughput: three back-to-back commands, results at cycles 4, 7, 10
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_opcode = 4'd2; in_a = 8'h01; in_b = 8'h01;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 1) begin in_opcode = 4'd3; in_a = 8'h09; in_b = 8'h03; end
      else if (c == 2) begin in_opcode = 4'd5; in_a = 8'h0F; in_b = 8'h30; end
      else in_valid = 1'b0;
      if (res_valid) hits.push_back(c);
    end
    chk("tp_count", hits.size(), 3);
    if (hits.size() == 3) begin
      chk("tp_first", hits[0], 4);
      chk("tp_gap1", hits[1] - hits[0], 3);
      chk("tp_gap2", hits[2] - hits[1], 3);
    end

    // Reset in the middle of CAPTURE with a second command still queued
    in_valid = 1'b1;
    in_opcode = 4'd2; in_a = 8'h11; in_b = 8'h22;
    cyc();
    in_opcode = 4'd6; in_a = 8'h33; in_b = 8'h44;
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("mid_capture_oe", alu_oe, 1'b1);
    rst = 1'b1;
    e0 = en_total;
    cyc();
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_op_count", op_count, 16'd0);
    chk("mid_rst_oe", alu_oe, 1'b0);
    cyc();
    rst = 1'b0;
    repeat (6) cyc();
    chk("post_rst_res_valid", res_valid, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_no_issue", en_total - e0, 0);

    // Fill the FIFO behind a held result, then hold backpressure
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_opcode = 4'd3; in_a = 8'h05; in_b = 8'h07;
    cyc();
    in_valid = 1'b0;
    wait_res_valid(10, "fill_first");
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_ready", in_ready, 1'b1);
      in_valid  = 1'b1;
      in_opcode = 4'($urandom_range(2, 7));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    chk("fill_full", in_ready, 1'b0);
    e0 = en_total;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_data", res_data, exp_q[0][7:0]);
      chk("bp_flags", res_flags, exp_q[0][11:8]);
      chk("bp_en", alu_en, 1'b0);
    end
    chk("bp_no_issue", en_total - e0, 0);
    res_ready = 1'b1;
    wait_idle(60, "fill_drain");
    chk("fill_op_count", op_count, 16'd5);

    // Opcode 4'hF
    e0 = en_total;
    in_valid  = 1'b1;
    in_opcode = 4'hF; in_a = 8'h33; in_b = 8'h44;
    cyc();
    in_valid = 1'b0;
    wait_res_valid(10, "ill");
    chk("ill_word", {res_err, res_flags, res_data}, ref_result(4'hF, 8'h33, 8'h44));
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    chk("ill_err", res_err, 1'b1);
    chk("ill_data", res_data, 8'h00);
`else
    chk("ill_err", res_err, 1'b0);
`endif
    cyc();
    wait_idle(20, "ill_idle");
`ifdef ALU_SEQ_ILLEGAL_CHK_EN
    chk("ill_en_pulses", en_total - e0, 0);
`else
    chk("ill_en_pulses", en_total - e0, 1);
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_opcode = 4'($urandom_range(0, 15));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    wait_idle(100, "rnd_drain");
    chk("rnd_queue_empty", exp_q.size(), 0);
    chk("rnd_res_valid", res_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
